// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs one
// outstanding fetch on the SRAM-like bus, hands insts to IF/ID.
//
// Ports:
//   clk, rst             clock, sync active-high reset
//   if_stall_i           IF/ID not accepting this cycle
//   branch_flag_i        ID taken branch/jump
//   branch_target_i      branch/jump target
//   flush_i, flush_pc_i  exception/eret flush and its target
//   inst_req/inst_addr   bus request and fetch address
//   inst_addr_ok         bus accepted the address
//   inst_data_ok         bus returns inst_rdata
//   if_valid_o           if_pc_o/if_inst_o valid for IF/ID
//   stallreq_o           no instruction available (REQ/WAIT)
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {
    S_RST, S_REQ, S_WAIT, S_VALID
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              br_pend_q, br_pend_d;
  logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
  logic              cancel_q, cancel_d;
  logic [ADDR_W-1:0] fl_pc_q, fl_pc_d;
  logic              resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      addr_q    <= RESET_PC;
      pc_q      <= '0;
      inst_q    <= '0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
      cancel_q  <= 1'b0;
      fl_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      cancel_q  <= cancel_d;
      fl_pc_q   <= fl_pc_d;
    end
  end

  // A response counts in WAIT, or in REQ when it
  // arrives together with addr_ok.
  assign resp = inst_data_ok &&
    (state_q == S_WAIT ||
     (state_q == S_REQ && inst_addr_ok));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    cancel_d  = cancel_q;
    fl_pc_d   = fl_pc_q;

    // The in-flight/held fetch is the delay slot, so a
    // branch only records the redirect.
    if (flush_i) begin
      br_pend_d = 1'b0;
    end else if (branch_flag_i) begin
      br_pend_d = 1'b1;
      br_tgt_d  = branch_target_i;
    end

    case (state_q)
      S_RST: begin
        state_d = S_REQ;
        if (flush_i) addr_d = flush_pc_i;
      end
      S_REQ, S_WAIT: begin
        // Outstanding handshake must finish; remember
        // to drop its data and where to go next.
        if (flush_i) begin
          cancel_d = 1'b1;
          fl_pc_d  = flush_pc_i;
        end
        if (state_q == S_WAIT || inst_addr_ok)
          state_d = S_WAIT;
        if (resp) begin
          if (flush_i || cancel_q) begin
            state_d   = S_REQ;
            cancel_d  = 1'b0;
            br_pend_d = 1'b0;
            addr_d    = flush_i ? flush_pc_i : fl_pc_q;
          end else begin
            state_d = S_VALID;
            pc_d    = addr_q;
            inst_d  = inst_rdata;
          end
        end
      end
      S_VALID: begin
        if (flush_i) begin
          state_d = S_REQ;
          addr_d  = flush_pc_i;
        end else if (!if_stall_i) begin
          state_d   = S_REQ;
          br_pend_d = 1'b0;
          if (branch_flag_i)
            addr_d = branch_target_i;
          else if (br_pend_q)
            addr_d = br_tgt_q;
          else
            addr_d = pc_q + ADDR_W'(4);
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    inst_req   = (state_q == S_REQ);
    if_valid_o = (state_q == S_VALID);
    stallreq_o = (state_q == S_REQ) ||
                 (state_q == S_WAIT);
  end

  assign inst_addr = addr_q;
  assign if_pc_o   = pc_q;
  assign if_inst_o = inst_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a scoreboard
// of expected (pc, inst) deliveries.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_i     (if_stall_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .stallreq_o     (stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, check its address stays put for
  // `dly` stalled cycles, then accept it. With `same`,
  // data_ok rides along with addr_ok.
  task automatic req_phase(input logic [31:0] a,
                           input int dly,
                           input bit same,
                           input logic [31:0] d);
    int n = 0;
    while (!inst_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(inst_req), 32'd1);
    chk("req_addr", inst_addr, a);
    chk("req_stall", 32'(stallreq_o), 32'd1);
    for (int i = 0; i < dly; i++) begin
      step();
      chk("hold_req", 32'(inst_req), 32'd1);
      chk("hold_addr", inst_addr, a);
    end
    inst_addr_ok = 1'b1;
    if (same) begin
      inst_data_ok = 1'b1;
      inst_rdata   = d;
      sb.push_back('{pc: a, inst: d});
    end
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (!same) begin
      chk("wait_req", 32'(inst_req), 32'd0);
      chk("wait_stall", 32'(stallreq_o), 32'd1);
    end
  endtask

  task automatic data_phase(input logic [31:0] a,
                            input logic [31:0] d);
    sb.push_back('{pc: a, inst: d});
    inst_data_ok = 1'b1;
    inst_rdata   = d;
    step();
    inst_data_ok = 1'b0;
  endtask

  task automatic check_out(output exp_t e);
    e = '{pc: 32'hx, inst: 32'hx};
    chk("valid", 32'(if_valid_o), 32'd1);
    chk("v_stall", 32'(stallreq_o), 32'd0);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", if_pc_o, e.pc);
      chk("inst", if_inst_o, e.inst);
    end
  endtask

  initial begin
    exp_t e;
    rst             = 1'b1;
    if_stall_i      = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    flush_i         = 1'b0;
    flush_pc_i      = '0;
    inst_addr_ok    = 1'b0;
    inst_data_ok    = 1'b0;
    inst_rdata      = '0;
    step();
    step();
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    rst = 1'b0;

    // Basic sequential fetches.
    req_phase(32'h0, 0, 1'b0, '0);
    data_phase(32'h0, 32'h24010001);
    check_out(e);
    req_phase(32'h4, 0, 1'b0, '0);
    data_phase(32'h4, 32'h24020002);
    check_out(e);

    // addr_ok delayed 3 cycles.
    req_phase(32'h8, 3, 1'b0, '0);
    data_phase(32'h8, 32'h24030003);
    check_out(e);
    // addr_ok and data_ok in the same cycle.
    req_phase(32'hC, 0, 1'b1, 32'h2404000C);
    check_out(e);

    // Branch at 0x10 while 0x14 is in WAIT.
    req_phase(32'h10, 0, 1'b0, '0);
    data_phase(32'h10, 32'h10000040);
    check_out(e);
    req_phase(32'h14, 0, 1'b0, '0);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    data_phase(32'h14, 32'h24050014);
    check_out(e);
    req_phase(32'h100, 0, 1'b0, '0);
    data_phase(32'h100, 32'h24060100);
    check_out(e);

    // Flush in WAIT with data_ok same cycle and a
    // pending branch.
    req_phase(32'h104, 0, 1'b0, '0);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    flush_i       = 1'b1;
    flush_pc_i    = 32'h380;
    inst_data_ok  = 1'b1;
    inst_rdata    = 32'hDEADBEEF;
    step();
    flush_i      = 1'b0;
    inst_data_ok = 1'b0;
    chk("fl_valid", 32'(if_valid_o), 32'd0);
    chk("fl_addr", inst_addr, 32'h380);
    req_phase(32'h380, 0, 1'b0, '0);
    data_phase(32'h380, 32'h24070380);
    check_out(e);
    req_phase(32'h384, 0, 1'b0, '0);
    data_phase(32'h384, 32'h24080384);

    // Stall held in VALID for 4 cycles.
    if_stall_i = 1'b1;
    check_out(e);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_valid", 32'(if_valid_o), 32'd1);
      chk("st_pc", if_pc_o, e.pc);
      chk("st_inst", if_inst_o, e.inst);
      chk("st_req", 32'(inst_req), 32'd0);
    end
    if_stall_i = 1'b0;
    step();
    chk("st_next", inst_addr, 32'h388);
    chk("st_rel", 32'(if_valid_o), 32'd0);
    step();
    chk("st_once", inst_addr, 32'h388);

    // Flush in REQ: handshake completes, data dropped.
    flush_i      = 1'b1;
    flush_pc_i   = 32'hFFFFFFFC;
    inst_addr_ok = 1'b1;
    step();
    flush_i      = 1'b0;
    inst_addr_ok = 1'b0;
    chk("flr_wait", 32'(stallreq_o), 32'd1);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBAD0BAD0;
    step();
    inst_data_ok = 1'b0;
    chk("flr_valid", 32'(if_valid_o), 32'd0);
    chk("flr_addr", inst_addr, 32'hFFFFFFFC);

    // Address wrap.
    req_phase(32'hFFFFFFFC, 0, 1'b0, '0);
    data_phase(32'hFFFFFFFC, 32'h2409FFFC);
    check_out(e);
    req_phase(32'h0, 0, 1'b0, '0);

    // Reset during WAIT, trailing data_ok ignored.
    rst = 1'b1;
    step();
    chk("mr_req", 32'(inst_req), 32'd0);
    chk("mr_addr", inst_addr, 32'h0);
    chk("mr_valid", 32'(if_valid_o), 32'd0);
    chk("mr_pc", if_pc_o, 32'h0);
    chk("mr_inst", if_inst_o, 32'h0);
    chk("mr_stall", 32'(stallreq_o), 32'd0);
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBAD1BAD1;
    step();
    inst_data_ok = 1'b0;
    chk("mr_valid2", 32'(if_valid_o), 32'd0);
    chk("mr_req2", 32'(inst_req), 32'd1);
    chk("mr_addr2", inst_addr, 32'h0);
    req_phase(32'h0, 0, 1'b0, '0);
    data_phase(32'h0, 32'h240A0000);
    check_out(e);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
